// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for the program memory: fetch PC, 2-entry prefetch
// buffer, epoch-based squashing on redirect, and round-robin sharing with debug reads.
module imem_fetch_ctrl #(
  parameter int AW = 8,
  parameter int IW = 6,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [IW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [IW-1:0] mem_rdata
);

  logic [AW-1:0] fpc_q, fpc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [IW-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic          infl_v_q, infl_v_d;
  logic          infl_dbg_q, infl_dbg_d;
  logic [AW-1:0] infl_pc_q, infl_pc_d;
  logic          infl_ep_q, infl_ep_d;
  logic          epoch_q, epoch_d;
  logic          last_dbg_q, last_dbg_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [IW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic          pop_s, push_s, cpu_want_s, cpu_win_s, dbg_win_s;
  logic [2:0]    occ_s;

  // Fetch demand and round-robin arbitration; the port is held idle while in reset
  always_comb begin
    pop_s      = (cnt_q != 2'd0) & instr_ready;
    occ_s      = {1'b0, cnt_q} + {2'b00, infl_v_q & ~infl_dbg_q};
    cpu_want_s = ~redirect & (occ_s < (3'd2 + {2'b00, pop_s}));
    push_s     = infl_v_q & ~infl_dbg_q & (infl_ep_q == epoch_q) & ~redirect;
    if (rst) begin
      cpu_win_s = 1'b0;
      dbg_win_s = 1'b0;
    end else if (cpu_want_s & dbg_req) begin
      cpu_win_s = last_dbg_q;
      dbg_win_s = ~last_dbg_q;
    end else begin
      cpu_win_s = cpu_want_s;
      dbg_win_s = dbg_req;
    end
  end

  assign mem_en      = cpu_win_s | dbg_win_s;
  assign mem_addr    = cpu_win_s ? fpc_q : (dbg_win_s ? dbg_addr : {AW{1'b0}});
  assign dbg_gnt     = dbg_win_s;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr       = ins0_q;
  assign instr_pc    = pc0_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign dbg_rdata   = dbg_rdata_q;

  // Next-state: fetch PC, prefetch FIFO (slot 0 is the head), in-flight tag, epoch
  always_comb begin
    fpc_d      = fpc_q;
    cnt_d      = cnt_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    ins0_d     = ins0_q;
    ins1_d     = ins1_q;
    epoch_d    = epoch_q;
    last_dbg_d = last_dbg_q;
    infl_v_d   = cpu_win_s | dbg_win_s;
    infl_dbg_d = dbg_win_s;
    infl_pc_d  = fpc_q;
    infl_ep_d  = epoch_q;
    if (cpu_want_s & dbg_req) begin
      last_dbg_d = dbg_win_s;
    end else begin
      last_dbg_d = last_dbg_q;
    end
    if (redirect) begin
      fpc_d   = redirect_addr;
      epoch_d = ~epoch_q;
      cnt_d   = 2'd0;
    end else begin
      if (cpu_win_s) begin
        fpc_d = fpc_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        fpc_d = fpc_q;
      end
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            pc0_d  = infl_pc_q;
            ins0_d = mem_rdata;
          end else begin
            pc1_d  = infl_pc_q;
            ins1_d = mem_rdata;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          pc0_d  = pc1_q;
          ins0_d = ins1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            pc0_d  = infl_pc_q;
            ins0_d = mem_rdata;
          end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = infl_pc_q;
            ins1_d = mem_rdata;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
    dbg_rvalid_d = infl_v_q & infl_dbg_q;
    if (infl_v_q & infl_dbg_q) begin
      dbg_rdata_d = mem_rdata;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q        <= RESET_PC;
      cnt_q        <= 2'd0;
      pc0_q        <= {AW{1'b0}};
      pc1_q        <= {AW{1'b0}};
      ins0_q       <= {IW{1'b0}};
      ins1_q       <= {IW{1'b0}};
      infl_v_q     <= 1'b0;
      infl_dbg_q   <= 1'b0;
      infl_pc_q    <= {AW{1'b0}};
      infl_ep_q    <= 1'b0;
      epoch_q      <= 1'b0;
      last_dbg_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= {IW{1'b0}};
    end else begin
      fpc_q        <= fpc_d;
      cnt_q        <= cnt_d;
      pc0_q        <= pc0_d;
      pc1_q        <= pc1_d;
      ins0_q       <= ins0_d;
      ins1_q       <= ins1_d;
      infl_v_q     <= infl_v_d;
      infl_dbg_q   <= infl_dbg_d;
      infl_pc_q    <= infl_pc_d;
      infl_ep_q    <= infl_ep_d;
      epoch_q      <= epoch_d;
      last_dbg_q   <= last_dbg_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: fill, backpressure, redirect squash, debug
// arbitration, PC wrap and asynchronous reset with a debug read in flight.
module tb_imem_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       instr_valid;
  logic [5:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       dbg_req;
  logic [7:0] dbg_addr;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [5:0] dbg_rdata;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [5:0] mem_rdata = 6'h00;

  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(.AW(8), .IW(6), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] mv(input logic [7:0] a);
    case (a)
      8'h00:   mv = 6'h12;
      8'h01:   mv = 6'h28;
      8'h02:   mv = 6'h3B;
      8'h1C:   mv = 6'h0E;
      default: mv = a[5:0] ^ 6'h15;
    endcase
  endfunction

  // Program memory with one-cycle synchronous read
  always @(posedge clk) if (mem_en) mem_rdata <= mv(mem_addr);

  // The prefetch buffer must never exceed two entries
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (dut.cnt_q <= 2'd2) else begin
        errors++;
        $error("FAIL overflow: observed %0d expected <=2", dut.cnt_q);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, {24'd0, instr_pc}, {24'd0, pc});
    chk({tag, "_instr"}, {26'd0, instr}, {26'd0, mv(pc)});
  endtask

  task automatic chk_issue(input string tag, input logic [7:0] a);
    chk({tag, "_en"}, {31'd0, mem_en}, 32'd1);
    chk({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, a});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, {26'd0, instr}, 32'd0);
    chk({tag, "_ipc"}, {24'd0, instr_pc}, 32'd0);
    chk({tag, "_gnt"}, {31'd0, dbg_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, dbg_rvalid}, 32'd0);
    chk({tag, "_rdata"}, {26'd0, dbg_rdata}, 32'd0);
    chk({tag, "_men"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_maddr"}, {24'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
    instr_ready = 1'b0; dbg_req = 1'b0; dbg_addr = 8'h00;
    repeat (3) cyc();
    #2 chk_all_zero("reset");

    // Fill
    cyc(); rst = 1'b0; instr_ready = 1'b1;
    #2 chk_issue("c0", 8'h00); chk("c0_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk_issue("c1", 8'h01); chk("c1_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk_issue("c2", 8'h02); chk_head("c2", 8'h00);
    cyc(); #2 chk_issue("c3", 8'h03); chk_head("c3", 8'h01);
    cyc(); #2 chk_issue("c4", 8'h04); chk_head("c4", 8'h02);
    cyc(); #2 chk_issue("c5", 8'h05); chk_head("c5", 8'h03);

    // Redirect with address 05 in flight and a pop of 04 requested
    cyc(); redirect = 1'b1; redirect_addr = 8'h1A;
    #2 chk("c6_men", {31'd0, mem_en}, 32'd0);
    cyc(); redirect = 1'b0;
    #2 chk_issue("c7", 8'h1A); chk("c7_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk_issue("c8", 8'h1B); chk("c8_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk_head("c9", 8'h1A);
    cyc(); #2 chk_head("c10", 8'h1B);
    cyc(); #2 chk_head("c11", 8'h1C);

    // Backpressure for 5 cycles
    cyc(); instr_ready = 1'b0;
    #2 chk("c12_men", {31'd0, mem_en}, 32'd0); chk_head("c12", 8'h1D);
    for (int i = 0; i < 4; i++) begin
      cyc(); #2;
      chk("stall_men", {31'd0, mem_en}, 32'd0);
      chk("stall_occ", {30'd0, dut.cnt_q}, 32'd2);
      chk_head("stall", 8'h1D);
    end
    cyc(); instr_ready = 1'b1;
    #2 chk_issue("c17", 8'h1F); chk_head("c17", 8'h1D);
    cyc(); #2 chk_issue("c18", 8'h20); chk_head("c18", 8'h1E);
    cyc(); #2 chk_head("c19", 8'h1F);
    cyc(); #2 chk_head("c20", 8'h20);

    // Debug contention: debug first, then alternating
    cyc(); dbg_req = 1'b1; dbg_addr = 8'h1C;
    #2 chk("c21_gnt", {31'd0, dbg_gnt}, 32'd1); chk_issue("c21", 8'h1C); chk_head("c21", 8'h21);
    cyc(); #2 chk("c22_gnt", {31'd0, dbg_gnt}, 32'd0); chk_issue("c22", 8'h23);
    chk("c22_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    cyc(); #2 chk("c23_gnt", {31'd0, dbg_gnt}, 32'd1); chk("c23_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("c23_rdata", {26'd0, dbg_rdata}, 32'h0E); chk("c23_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk("c24_gnt", {31'd0, dbg_gnt}, 32'd0); chk_issue("c24", 8'h24); chk_head("c24", 8'h23);
    chk("c24_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    cyc(); #2 chk("c25_gnt", {31'd0, dbg_gnt}, 32'd1); chk("c25_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    cyc(); dbg_req = 1'b0;
    #2 chk("c26_gnt", {31'd0, dbg_gnt}, 32'd0); chk_issue("c26", 8'h25); chk_head("c26", 8'h24);
    chk("c26_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    cyc(); #2 chk("c27_rvalid", {31'd0, dbg_rvalid}, 32'd1); chk("c27_rdata", {26'd0, dbg_rdata}, 32'h0E);
    chk_issue("c27", 8'h26);

    // Wrap through FF
    cyc(); redirect = 1'b1; redirect_addr = 8'hFE;
    #2 chk("c28_men", {31'd0, mem_en}, 32'd0); chk_head("c28", 8'h25);
    cyc(); redirect = 1'b0;
    #2 chk_issue("c29", 8'hFE); chk("c29_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk_issue("c30", 8'hFF);
    cyc(); #2 chk_issue("c31", 8'h00); chk_head("c31", 8'hFE);
    cyc(); #2 chk_issue("c32", 8'h01); chk_head("c32", 8'hFF);
    cyc(); #2 chk_head("c33", 8'h00);
    cyc(); #2 chk_head("c34", 8'h01);

    // Debug granted alongside a redirect, then async reset before its response
    cyc(); redirect = 1'b1; redirect_addr = 8'h80; dbg_req = 1'b1; dbg_addr = 8'h1C;
    #2 chk("c35_gnt", {31'd0, dbg_gnt}, 32'd1); chk_issue("c35", 8'h1C);
    cyc(); redirect = 1'b0; dbg_req = 1'b0;
    #2 chk_issue("c36", 8'h80);
    rst = 1'b1;
    #1 chk_all_zero("midrst");
    #2 rst = 1'b0;
    #1 chk_issue("restart", 8'h00);
    cyc(); #2 chk("c37_rvalid", {31'd0, dbg_rvalid}, 32'd0); chk_issue("c37", 8'h01);
    chk("c37_ivalid", {31'd0, instr_valid}, 32'd0);
    cyc(); #2 chk("c38_rvalid", {31'd0, dbg_rvalid}, 32'd0); chk_head("c38", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
